// File: rtl/code_entry_ctrl_if.sv
// code_entry_ctrl_if
//   Bundles the switch input and every display/status output of the
//   code-entry front end so that the controller and its user share one port.
//
//   sw       16  raw switches; sw[15] selects player, sw[14:0] carry the code
//   seg       7  segment cathodes, active-low, bit6..0 = g..a
//   an        4  digit anodes, active-low, an[3] is the leftmost digit
//   dp        1  decimal point, active-low
//   led      16  progress LEDs (led[15] mirrors code_ok)
//   code_ok   1  high once the code has been accepted
//   player    1  0 = player 1, 1 = player 2
//   blink     1  slow square wave for the OLED menu renderer
//
//   master: drives sw, observes the rest (board / bench side)
//   slave : the controller
interface code_entry_ctrl_if;
    logic [15:0] sw;
    logic [6:0]  seg;
    logic [3:0]  an;
    logic        dp;
    logic [15:0] led;
    logic        code_ok;
    logic        player;
    logic        blink;

    modport master (
        output sw,
        input  seg, an, dp, led, code_ok, player, blink
    );

    modport slave (
        input  sw,
        output seg, an, dp, led, code_ok, player, blink
    );
endinterface

// File: rtl/code_entry_ctrl.sv
// code_entry_ctrl
//   Start-code front end: synchronises the switches, tracks ordered entry of
//   a three-switch code, holds a confirm display, then shows the player
//   banner. Also runs the 4-digit seven-segment scan and a blink strobe.
//
//   clock  in   system clock
//   reset  in   asynchronous, active-high reset
//   bus    slave modport of code_entry_ctrl_if (sw in; seg/an/dp/led/
//          code_ok/player/blink out)
//
//   Parameters: SCAN_DIV (scan tick every SCAN_DIV+1 clocks), HOLD_TICKS
//   (ticks spent in CONFIRM), BLINK_TICKS (ticks per blink half-period),
//   CODE0/1/2 (distinct switch indices 0..14 forming the code).
module code_entry_ctrl #(
    parameter int SCAN_DIV    = 249_999,
    parameter int HOLD_TICKS  = 400,
    parameter int BLINK_TICKS = 100,
    parameter int CODE0       = 2,
    parameter int CODE1       = 0,
    parameter int CODE2       = 6
) (
    input logic              clock,
    input logic              reset,
    code_entry_ctrl_if.slave bus
);

    localparam int SCW = $clog2(SCAN_DIV + 1);
    localparam int HCW = $clog2(HOLD_TICKS + 1);
    localparam int BCW = $clog2(BLINK_TICKS + 1);

    localparam logic [SCW-1:0] SCAN_LAST  = SCW'(SCAN_DIV);
    localparam logic [HCW-1:0] HOLD_LAST  = HCW'(HOLD_TICKS - 1);
    localparam logic [BCW-1:0] BLINK_LAST = BCW'(BLINK_TICKS - 1);

    // Cumulative accepted-switch masks for each entry step.
    localparam logic [14:0] M0 = 15'd1 << CODE0;
    localparam logic [14:0] M1 = M0 | (15'd1 << CODE1);
    localparam logic [14:0] M2 = M1 | (15'd1 << CODE2);

    localparam logic [6:0] G_P     = 7'b0001100;
    localparam logic [6:0] G_E     = 7'b0000110;
    localparam logic [6:0] G_R     = 7'b0101111;
    localparam logic [6:0] G_BLANK = 7'b1111111;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_GOT1,
        ST_GOT2,
        ST_CONFIRM,
        ST_PLAYER,
        ST_FAIL
    } state_t;

    logic [15:0]    sw_p0;
    logic [15:0]    ss;
    logic [SCW-1:0] scan_cnt;
    logic           tick;
    logic [HCW-1:0] hold_cnt;
    logic [BCW-1:0] blink_cnt;
    logic [1:0]     idx;
    logic [1:0]     idx_nxt;
    state_t         state;
    state_t         state_nxt;

    logic [6:0]     seg_r;
    logic [3:0]     an_r;
    logic [15:0]    led_r;
    logic           code_ok_r;
    logic           player_r;
    logic           blink_r;

    function automatic logic [6:0] digit_glyph(input logic [3:0] d);
        case (d)
            4'd0:    return 7'b1000000;
            4'd1:    return 7'b1111001;
            4'd2:    return 7'b0100100;
            4'd3:    return 7'b0110000;
            4'd4:    return 7'b0011001;
            4'd5:    return 7'b0010010;
            4'd6:    return 7'b0000010;
            4'd7:    return 7'b1111000;
            4'd8:    return 7'b0000000;
            4'd9:    return 7'b0010000;
            default: return G_BLANK;
        endcase
    endfunction

    // Content of digit i (0 = leftmost) for a given state.
    function automatic logic [6:0] cell_glyph(input state_t st, input logic [1:0] i,
                                              input logic pl);
        logic [6:0] g;
        g = G_BLANK;
        case (st)
            ST_GOT1: begin
                if (i == 2'd0) g = digit_glyph(4'(CODE0));
            end
            ST_GOT2: begin
                if (i == 2'd0)      g = digit_glyph(4'(CODE0));
                else if (i == 2'd1) g = digit_glyph(4'(CODE1));
            end
            ST_CONFIRM: begin
                if (i == 2'd0)      g = digit_glyph(4'(CODE0));
                else if (i == 2'd1) g = digit_glyph(4'(CODE1));
                else if (i == 2'd2) g = digit_glyph(4'(CODE2));
            end
            ST_PLAYER: begin
                if (i == 2'd0)      g = G_P;
                else if (i == 2'd1) g = digit_glyph(pl ? 4'd2 : 4'd1);
            end
            ST_FAIL: begin
                if (i == 2'd0)                     g = G_E;
                else if (i == 2'd1 || i == 2'd2)   g = G_R;
            end
            default: g = G_BLANK;
        endcase
        return g;
    endfunction

    // Entry must follow the masks exactly; dropping or adding any other
    // switch is an error, and the error state waits for all switches off.
    function automatic state_t fsm_next(input state_t st, input logic [14:0] s,
                                        input logic hold_done);
        state_t nxt;
        nxt = st;
        case (st)
            ST_IDLE:    if (s == M0) nxt = ST_GOT1;
                        else if (s != 15'd0) nxt = ST_FAIL;
            ST_GOT1:    if (s == M1) nxt = ST_GOT2;
                        else if (s != M0) nxt = ST_FAIL;
            ST_GOT2:    if (s == M2) nxt = ST_CONFIRM;
                        else if (s != M1) nxt = ST_FAIL;
            ST_FAIL:    if (s == 15'd0) nxt = ST_IDLE;
            ST_CONFIRM: if (hold_done) nxt = ST_PLAYER;
            ST_PLAYER:  nxt = ST_PLAYER;
            default:    nxt = ST_IDLE;
        endcase
        return nxt;
    endfunction

    function automatic logic [14:0] led_mask(input state_t st);
        case (st)
            ST_GOT1:              return M0;
            ST_GOT2:              return M1;
            ST_CONFIRM, ST_PLAYER: return M2;
            ST_FAIL:              return 15'h7FFF;
            default:              return 15'd0;
        endcase
    endfunction

    assign tick    = (scan_cnt == SCAN_LAST);
    assign idx_nxt = idx + 2'd1;

    always_comb begin
        state_nxt = fsm_next(state, ss[14:0], tick && (hold_cnt == HOLD_LAST));
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sw_p0     <= '0;
            ss        <= '0;
            scan_cnt  <= '0;
            hold_cnt  <= '0;
            blink_cnt <= '0;
            idx       <= '0;
            state     <= ST_IDLE;
            seg_r     <= G_BLANK;
            an_r      <= 4'b1111;
            led_r     <= '0;
            code_ok_r <= 1'b0;
            player_r  <= 1'b0;
            blink_r   <= 1'b0;
        end else begin
            // stage p0 -> p1: two-flop switch synchroniser
            sw_p0 <= bus.sw;
            ss    <= sw_p0;

            // stage p1 -> state: FSM and its registered status outputs
            scan_cnt  <= tick ? '0 : scan_cnt + 1'b1;
            state     <= state_nxt;
            code_ok_r <= (state_nxt == ST_CONFIRM) || (state_nxt == ST_PLAYER);
            led_r     <= {(state_nxt == ST_CONFIRM) || (state_nxt == ST_PLAYER),
                          led_mask(state_nxt)};

            // Held at zero outside CONFIRM, so it is clear on every entry.
            if (state != ST_CONFIRM)
                hold_cnt <= '0;
            else if (tick)
                hold_cnt <= hold_cnt + 1'b1;

            if (state == ST_PLAYER)
                player_r <= ss[15];

            // state -> display: anode and cathodes move together on a tick,
            // using the state as it was before this edge.
            if (tick) begin
                idx   <= idx_nxt;
                an_r  <= ~(4'b1000 >> idx_nxt);
                seg_r <= cell_glyph(state, idx_nxt, player_r);
                if (blink_cnt == BLINK_LAST) begin
                    blink_cnt <= '0;
                    blink_r   <= ~blink_r;
                end else begin
                    blink_cnt <= blink_cnt + 1'b1;
                end
            end
        end
    end

    assign bus.seg     = seg_r;
    assign bus.an      = an_r;
    assign bus.dp      = 1'b1;
    assign bus.led     = led_r;
    assign bus.code_ok = code_ok_r;
    assign bus.player  = player_r;
    assign bus.blink   = blink_r;

endmodule

// File: tb/tb_code_entry_ctrl.sv
// tb_code_entry_ctrl
//   Directed bench for code_entry_ctrl with a short scan period
//   (SCAN_DIV=3, HOLD_TICKS=8, BLINK_TICKS=2, code 2-0-6).
module tb_code_entry_ctrl;

    localparam int SCAN_DIV    = 3;
    localparam int HOLD_TICKS  = 8;
    localparam int BLINK_TICKS = 2;

    localparam logic [6:0] G0 = 7'b1000000;
    localparam logic [6:0] G1 = 7'b1111001;
    localparam logic [6:0] G2 = 7'b0100100;
    localparam logic [6:0] G6 = 7'b0000010;
    localparam logic [6:0] GP = 7'b0001100;
    localparam logic [6:0] GE = 7'b0000110;
    localparam logic [6:0] GR = 7'b0101111;
    localparam logic [6:0] GB = 7'b1111111;

    // Four digits, leftmost first.
    localparam logic [27:0] D_IDLE = {GB, GB, GB, GB};
    localparam logic [27:0] D_GOT1 = {G2, GB, GB, GB};
    localparam logic [27:0] D_GOT2 = {G2, G0, GB, GB};
    localparam logic [27:0] D_CONF = {G2, G0, G6, GB};
    localparam logic [27:0] D_ERR  = {GE, GR, GR, GB};
    localparam logic [27:0] D_P1   = {GP, G1, GB, GB};

    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    code_entry_ctrl_if bus ();

    code_entry_ctrl #(
        .SCAN_DIV   (SCAN_DIV),
        .HOLD_TICKS (HOLD_TICKS),
        .BLINK_TICKS(BLINK_TICKS),
        .CODE0      (2),
        .CODE1      (0),
        .CODE2      (6)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    typedef struct {
        logic [15:0] sw;
        logic [15:0] led;
        logic [27:0] digs;
    } vec_t;

    vec_t vecs[18];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic fail_now(input string name);
        n_tests++;
        n_fail++;
        $display("FAIL %s: bound expired, got no event, expected one", name);
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    function automatic int an_idx(input logic [3:0] a);
        case (a)
            4'h7:    return 0;
            4'hB:    return 1;
            4'hD:    return 2;
            4'hE:    return 3;
            default: return -1;
        endcase
    endfunction

    // Watch four consecutive digit updates and compare each against digs.
    task automatic scan_check(input string name, input logic [27:0] digs);
        for (int k = 0; k < 4; k++) begin
            logic [3:0] prev;
            int w;
            int i;
            prev = bus.an;
            w = 0;
            while (bus.an === prev && w < 12) begin
                step(1);
                w++;
            end
            if (bus.an === prev) begin
                fail_now({name, "_scan"});
                return;
            end
            i = an_idx(bus.an);
            if (i < 0) begin
                check({name, "_an"}, 32'(bus.an), 32'hE);
            end else begin
                check($sformatf("%s_d%0d", name, i), 32'(bus.seg), 32'(digs[27-7*i -: 7]));
            end
        end
    endtask

    // Reset asserted between edges, outputs checked before any edge, then
    // the first scan tick and blink toggles counted from release.
    task automatic reset_seq(input string name);
        #2;
        reset  = 1'b1;
        bus.sw = 16'h0000;
        #1;
        check({name, "_seg"},     32'(bus.seg),     32'h7F);
        check({name, "_an"},      32'(bus.an),      32'hF);
        check({name, "_dp"},      32'(bus.dp),      32'h1);
        check({name, "_led"},     32'(bus.led),     32'h0);
        check({name, "_code_ok"}, 32'(bus.code_ok), 32'h0);
        check({name, "_player"},  32'(bus.player),  32'h0);
        check({name, "_blink"},   32'(bus.blink),   32'h0);
        step(2);
        reset = 1'b0;
        for (int e = 1; e <= 16; e++) begin
            step(1);
            if (e == 3)  check({name, "_an_e3"},     32'(bus.an),    32'hF);
            if (e == 4)  check({name, "_an_e4"},     32'(bus.an),    32'hB);
            if (e == 7)  check({name, "_blink_e7"},  32'(bus.blink), 32'h0);
            if (e == 8)  check({name, "_blink_e8"},  32'(bus.blink), 32'h1);
            if (e == 15) check({name, "_blink_e15"}, 32'(bus.blink), 32'h1);
            if (e == 16) check({name, "_blink_e16"}, 32'(bus.blink), 32'h0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0]  = '{16'h0000, 16'h0000, D_IDLE};
        vecs[1]  = '{16'h0001, 16'h7FFF, D_ERR};   // foreign switch from IDLE
        vecs[2]  = '{16'h0045, 16'h7FFF, D_ERR};   // error waits for all-off
        vecs[3]  = '{16'h0000, 16'h0000, D_IDLE};
        vecs[4]  = '{16'h0004, 16'h0004, D_GOT1};
        vecs[5]  = '{16'h0005, 16'h0005, D_GOT2};
        vecs[6]  = '{16'h0004, 16'h7FFF, D_ERR};   // backing out of GOT2
        vecs[7]  = '{16'h0045, 16'h7FFF, D_ERR};
        vecs[8]  = '{16'h0000, 16'h0000, D_IDLE};
        vecs[9]  = '{16'h0004, 16'h0004, D_GOT1};
        vecs[10] = '{16'h0044, 16'h7FFF, D_ERR};   // out of order in GOT1
        vecs[11] = '{16'h0000, 16'h0000, D_IDLE};
        vecs[12] = '{16'h0004, 16'h0004, D_GOT1};
        vecs[13] = '{16'h0005, 16'h0005, D_GOT2};
        vecs[14] = '{16'h0085, 16'h7FFF, D_ERR};   // extra switch in GOT2
        vecs[15] = '{16'h0000, 16'h0000, D_IDLE};
        vecs[16] = '{16'h8004, 16'h0004, D_GOT1};  // sw[15] plays no part in the code
        vecs[17] = '{16'h8005, 16'h0005, D_GOT2};

        bus.sw = 16'h0000;
        step(1);
        reset_seq("rst0");

        for (int v = 0; v < 18; v++) begin
            bus.sw = vecs[v].sw;
            step(10);
            check($sformatf("vec%0d_led", v),     32'(bus.led),     32'(vecs[v].led));
            check($sformatf("vec%0d_code_ok", v), 32'(bus.code_ok), 32'h0);
            check($sformatf("vec%0d_player", v),  32'(bus.player),  32'h0);
            scan_check($sformatf("vec%0d", v), vecs[v].digs);
        end

        // Third switch: code_ok appears on the third edge.
        bus.sw = 16'h0045;
        for (int e = 1; e <= 3; e++) begin
            step(1);
            check($sformatf("confirm_entry_e%0d", e), 32'(bus.code_ok), (e == 3) ? 32'h1 : 32'h0);
        end

        // CONFIRM for exactly 8 ticks (8 digit updates), switches scrambled;
        // the 9th update onwards shows the player banner.
        begin
            int         changes;
            int         clks;
            int         last_blink;
            logic [3:0] prev_an;
            logic       prev_blink;
            logic [27:0] d;
            int         i;
            changes    = 0;
            clks       = 0;
            last_blink = -1;
            prev_an    = bus.an;
            prev_blink = bus.blink;
            while (changes < 12 && clks < 100) begin
                if (changes < 8) bus.sw = {1'b0, 15'($urandom)};
                step(1);
                clks++;
                check("hold_led", 32'(bus.led), 32'h8045);
                if (bus.blink !== prev_blink) begin
                    if (last_blink >= 0) check("blink_period", 32'(clks - last_blink), 32'd8);
                    last_blink = clks;
                    prev_blink = bus.blink;
                end
                if (bus.an !== prev_an) begin
                    changes++;
                    prev_an = bus.an;
                    d = (changes <= 8) ? D_CONF : D_P1;
                    i = an_idx(bus.an);
                    if (i < 0)
                        check("hold_an", 32'(bus.an), 32'hE);
                    else
                        check($sformatf("hold_upd%0d_d%0d", changes, i), 32'(bus.seg),
                              32'(d[27-7*i -: 7]));
                end
            end
            if (changes < 12) fail_now("hold_updates");
        end

        // Player select follows sw[15] live in PLAYER.
        bus.sw = 16'h8045;
        step(2);
        check("player_e2", 32'(bus.player), 32'h0);
        step(1);
        check("player_e3", 32'(bus.player), 32'h1);
        begin
            logic [3:0] prev_an;
            bit         seen;
            seen = 1'b0;
            for (int w = 0; w < 20 && !seen; w++) begin
                prev_an = bus.an;
                step(1);
                if (bus.an !== prev_an && bus.an === 4'hB) seen = 1'b1;
            end
            if (seen) check("player2_glyph", 32'(bus.seg), 32'(G2));
            else      fail_now("player2_glyph");
        end
        check("player_code_ok", 32'(bus.code_ok), 32'h1);
        check("player_led",     32'(bus.led),     32'h8045);

        reset_seq("rst_player");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
